// File: rtl/reg_access_arbiter_if.sv
// Two-requester shared-register bus: requester handshakes plus register strobes.
interface reg_access_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_write;
  logic [WIDTH-1:0] req0_wdata;
  logic             req0_ready;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_rdata;

  logic             req1_valid;
  logic             req1_write;
  logic [WIDTH-1:0] req1_wdata;
  logic             req1_ready;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_rdata;

  logic             reg_write;
  logic             reg_read;
  logic [WIDTH-1:0] reg_wdata;
  logic [WIDTH-1:0] reg_rdata;
  logic             busy;

  modport master (
    output req0_valid, req0_write, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_write, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  reg_write, reg_read, reg_wdata,
    output reg_rdata,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_write, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_write, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output reg_write, reg_read, reg_wdata,
    input  reg_rdata,
    output busy
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// Two-port arbiter serialising accesses to one shared register, fixed 4-cycle slot.
// Define REG_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (port 0).
module reg_access_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  reg_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             r_wr;
  logic             r_id;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rsp0_rdata;
  logic [WIDTH-1:0] r_rsp1_rdata;

  logic             w_any;
  logic             w_gnt1;
  logic             w_accept;

`ifdef REG_ARB_ROUND_ROBIN_EN
  logic             r_last;

  // tie goes to whoever was not granted last
  always_comb begin
    w_gnt1 = bus.req1_valid &
             (~bus.req0_valid | ~r_last);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt1;
    end
  end
`else
  always_comb begin
    w_gnt1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  always_comb begin
    w_any    = bus.req0_valid | bus.req1_valid;
    w_accept = (r_state == IDLE) & w_any & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_id    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_id <= w_gnt1;
      if (w_gnt1) begin
        r_wr    <= bus.req1_write;
        r_wdata <= bus.req1_wdata;
      end else begin
        r_wr    <= bus.req0_write;
        r_wdata <= bus.req0_wdata;
      end
    end
  end

  // response regs double as the capture point; the loser keeps its old value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else if (r_state == WAIT) begin
      if (r_id) begin
        r_rsp1_rdata <= r_wr ? '0 : bus.reg_rdata;
      end else begin
        r_rsp0_rdata <= r_wr ? '0 : bus.reg_rdata;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_read   = 1'b0;
    bus.reg_wdata  = '0;
    bus.busy       = 1'b1;
    unique case (r_state)
      IDLE: begin
        bus.busy       = 1'b0;
        bus.req0_ready = w_accept & ~w_gnt1;
        bus.req1_ready = w_accept & w_gnt1;
        if (w_accept) begin
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        bus.reg_write = r_wr;
        bus.reg_read  = ~r_wr;
        bus.reg_wdata = r_wr ? r_wdata : '0;
        w_next        = WAIT;
      end
      WAIT: begin
        w_next = RESP;
      end
      RESP: begin
        bus.rsp0_valid = ~r_id;
        bus.rsp1_valid = r_id;
        w_next         = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign bus.rsp0_rdata = r_rsp0_rdata;
  assign bus.rsp1_rdata = r_rsp1_rdata;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: latency, arbitration, reset abort, random traffic.
module tb_reg_access_arbiter;
  localparam int W = 32;

  typedef struct {
    bit          id;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          cyc;
  } txn_t;

  typedef struct {
    bit          wr;
    logic [31:0] d;
  } cmd_t;

  typedef struct {
    bit id;
    int cyc;
  } gnt_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  reg_access_arbiter_if #(.WIDTH(W)) bus();

  reg_access_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  txn_t        sb[$];
  cmd_t        q0[$];
  cmd_t        q1[$];
  gnt_t        glog[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc0_n = 0;
  int          acc1_n = 0;
  logic [31:0] m_reg = '0;
  logic [31:0] reg_q = '0;
  logic [31:0] prev0 = '0;
  logic [31:0] prev1 = '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // shared register model: read data appears one clock after reg_read
  initial begin
    bus.reg_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.reg_write) reg_q <= bus.reg_wdata;
      if (bus.reg_read) bus.reg_rdata <= reg_q;
    end
  end

  initial begin
    int pops;
    pops = 0;
    bus.req0_valid = 1'b0;
    bus.req0_write = 1'b0;
    bus.req0_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pops != acc0_n) begin
        void'(q0.pop_front());
        pops++;
      end
      if (q0.size() != 0) begin
        bus.req0_valid = 1'b1;
        bus.req0_write = q0[0].wr;
        bus.req0_wdata = q0[0].d;
      end else begin
        bus.req0_valid = 1'b0;
      end
    end
  end

  initial begin
    int pops;
    pops = 0;
    bus.req1_valid = 1'b0;
    bus.req1_write = 1'b0;
    bus.req1_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pops != acc1_n) begin
        void'(q1.pop_front());
        pops++;
      end
      if (q1.size() != 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_write = q1[0].wr;
        bus.req1_wdata = q1[0].d;
      end else begin
        bus.req1_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    txn_t e;
    txn_t f;
    check("one_ready", bus.req0_ready & bus.req1_ready, 0);
    check("one_rsp", bus.rsp0_valid & bus.rsp1_valid, 0);
    check("strobe_excl", bus.reg_write & bus.reg_read, 0);
    check("ready_idle", (bus.req0_ready | bus.req1_ready) & bus.busy, 0);
    if (sb.size() != 0 && sb[0].cyc + 1 == cyc) begin
      check("strobe_wr", bus.reg_write, sb[0].wr);
      check("strobe_rd", bus.reg_read, !sb[0].wr);
      check("reg_wdata", bus.reg_wdata, sb[0].wr ? sb[0].wdata : 0);
    end else begin
      check("no_strobe", bus.reg_write | bus.reg_read, 0);
    end
    if (bus.rsp0_valid | bus.rsp1_valid) begin
      if (sb.size() == 0) begin
        check("rsp_spurious", 1, 0);
      end else begin
        f = sb.pop_front();
        check("rsp_id", bus.rsp1_valid, f.id);
        check("rsp_cyc", cyc, f.cyc + 3);
        check("rsp_rdata",
              f.id ? bus.rsp1_rdata : bus.rsp0_rdata, f.exp);
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc + 3) begin
      check("rsp_late", 0, 1);
      void'(sb.pop_front());
    end
    if (!reset) begin
      if (!bus.rsp0_valid) check("hold0", bus.rsp0_rdata, prev0);
      if (!bus.rsp1_valid) check("hold1", bus.rsp1_rdata, prev1);
    end
    prev0 = bus.rsp0_rdata;
    prev1 = bus.rsp1_rdata;
    if (bus.req0_ready | bus.req1_ready) begin
      e.id    = bus.req1_ready;
      e.wr    = e.id ? bus.req1_write : bus.req0_write;
      e.wdata = e.id ? bus.req1_wdata : bus.req0_wdata;
      e.exp   = e.wr ? 32'd0 : m_reg;
      e.cyc   = cyc;
      if (e.wr) m_reg = e.wdata;
      sb.push_back(e);
      glog.push_back('{e.id, cyc});
      if (e.id) acc1_n++;
      else acc0_n++;
    end
  end

  task automatic wait_drain(int lim);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 ||
            bus.busy) && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", n < lim, 1);
  endtask

  task automatic wait_grant(int lim);
    int n;
    n = 0;
    while (glog.size() == 0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant_timeout", n < lim, 1);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_rdy"}, bus.req0_ready | bus.req1_ready, 0);
    check({tag, "_rspv"}, bus.rsp0_valid | bus.rsp1_valid, 0);
    check({tag, "_strobe"}, bus.reg_write | bus.reg_read, 0);
    check({tag, "_wdata"}, bus.reg_wdata, 0);
    check({tag, "_rd0"}, bus.rsp0_rdata, 0);
    check({tag, "_rd1"}, bus.rsp1_rdata, 0);
  endtask

  initial begin
    bit exp_id;
    repeat (3) @(negedge clk);
    check_zero("rst");
    @(posedge clk);
    #2 reset = 1'b0;

    q0.push_back('{1'b1, 32'd34000});
    wait_drain(40);
    check("t1_reg", reg_q, 34000);
    check("t1_rd0", bus.rsp0_rdata, 0);

    q1.push_back('{1'b0, 32'd0});
    wait_drain(40);
    check("t2_rd1", bus.rsp1_rdata, 34000);

    glog.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b1, 32'd64});
      q1.push_back('{1'b1, 32'd20000});
    end
    wait_drain(100);
    check("tie_n", glog.size(), 8);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
`ifdef REG_ARB_ROUND_ROBIN_EN
      exp_id = i[0];
`else
      exp_id = 1'b0;
`endif
      check("tie_id", glog[i].id, exp_id);
      if (i > 0) check("tie_gap", glog[i].cyc - glog[i-1].cyc, 4);
    end

    glog.delete();
    q0.push_back('{1'b0, 32'd0});
    wait_grant(20);
    @(negedge clk);
    #1;
    q1.push_back('{1'b0, 32'd0});
    wait_drain(40);
    check("late_n", glog.size(), 2);
    if (glog.size() == 2) begin
      check("late_id0", glog[0].id, 0);
      check("late_id1", glog[1].id, 1);
      check("late_gap", glog[1].cyc - glog[0].cyc, 4);
    end

    glog.delete();
    q0.push_back('{1'b0, 32'd0});
    wait_grant(20);
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    check("wait_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    check_zero("abort");
    sb.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    glog.delete();
    q1.push_back('{1'b0, 32'd0});
    wait_drain(40);
    check("post_rst_n", glog.size(), 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        q1.push_back('{$urandom_range(0, 1) == 1, $urandom});
      else
        q0.push_back('{$urandom_range(0, 1) == 1, $urandom});
    end
    wait_drain(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data width of the shared register and all data ports.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a pending access.
REQ-005 req0_write  input  1  requester 0 access type: 1 write, 0 read.
REQ-006 req0_wdata  input  WIDTH  requester 0 write data.
REQ-007 req0_ready  output  1  one-cycle pulse: requester 0 request accepted this cycle.
REQ-008 rsp0_valid  output  1  one-cycle pulse: requester 0 access complete.
REQ-009 rsp0_rdata  output  WIDTH  read data for requester 0, valid with rsp0_valid.
REQ-010 req1_valid, req1_write, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: identical to REQ-004..009, for requester 1.
REQ-011 reg_write  output  1  write strobe to shared register.
REQ-012 reg_read  output  1  read strobe to shared register.
REQ-013 reg_wdata  output  WIDTH  data to shared register.
REQ-014 reg_rdata  input  WIDTH  shared register output; valid one clk after reg_read.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one-hot or binary encoding at implementer's choice.
REQ-017 IDLE: if any reqN_valid, select winner, assert its reqN_ready combinationally that cycle, latch write flag, wdata and winner id at posedge, go ISSUE; otherwise stay IDLE.
REQ-018 ISSUE: drive exactly one of reg_write/reg_read high for one cycle with reg_wdata = latched wdata (reg_wdata = 0 for reads); go WAIT.
REQ-019 WAIT: no strobes; at posedge capture reg_rdata into response register (reads only); go RESP.
REQ-020 RESP: assert rspN_valid for winner only, one cycle; rspN_rdata = captured data for reads, 0 for writes; go IDLE.
REQ-021 Fixed latency: ready in cycle k -> strobe in cycle k+1 -> rsp in cycle k+3; next accept no earlier than cycle k+4.
REQ-022 Requests seen in ISSUE/WAIT/RESP are not accepted; requester holds valid/write/wdata until its ready pulse.
REQ-023 At most one reqN_ready and at most one rspN_valid high in any cycle; reg_write and reg_read never high together.
REQ-024 Non-winner rspN_rdata holds its previous value.
REQ-025 Arbitration on simultaneous valid per Configuration section; single valid always wins immediately.

Reset
REQ-026 reset high forces state IDLE immediately, independent of clk.
REQ-027 Reset values: all ready, rsp_valid, reg_write, reg_read, busy = 0; rsp0_rdata, rsp1_rdata, reg_wdata = 0; last-grant register = 1.
REQ-028 Reset during ISSUE/WAIT/RESP aborts the transaction with no response; strobe already issued is not repeated.

Configuration
REQ-029 Macro REG_ARB_ROUND_ROBIN_EN defined: simultaneous requests granted to the requester not granted last; last-grant updated on every accept.
REQ-030 Macro undefined: fixed priority, requester 0 always wins ties; last-grant register absent.

Verification
REQ-031 Req0 write 34000 alone -> req0_ready cycle k, reg_write cycle k+1 with reg_wdata 34000, rsp0_valid cycle k+3, rsp0_rdata 0.
REQ-032 After REQ-031, req1 read -> reg_read cycle k+1, rsp1_valid cycle k+3, rsp1_rdata 34000.
REQ-033 Both valid continuously (writes 64 and 20000): with REG_ARB_ROUND_ROBIN_EN grants 0,1,0,1 every 4 cycles; without, grants 0,0,0,0.
REQ-034 Req1 raises valid during req0 WAIT -> no req1_ready until IDLE; req1 accepted exactly 4 cycles after req0 accept.
REQ-035 Reset asserted in WAIT of a read -> all outputs 0 same cycle, no rsp pulse, next request served normally with full latency.
REQ-036 Assertion checks over random traffic: REQ-023 invariants hold, every ready matched by exactly one rsp to the same requester.
